// File: rtl/cic3_readout_pkg.sv
// cic3_readout_pkg: shared row-readout defaults and the readout state type.
package cic3_readout_pkg;
   localparam int NUM_FILTERS = 12;
   localparam int DATA_W      = 25;
   localparam int CH_W        = 4;
   localparam int FRAME_W     = 16;
   typedef enum logic {IDLE, SEND} state_t;
endpackage

// File: rtl/cic3_prio_enc.sv
// cic3_prio_enc: lowest-set-bit encoder with a "single bit remaining" flag.
//   mask     in  N  pending channel mask
//   idx      out W  index of the lowest set bit (0 when mask is empty)
//   one_left out 1  exactly one bit of mask is set
module cic3_prio_enc
   import cic3_readout_pkg::*;
#(
   parameter int N = cic3_readout_pkg::NUM_FILTERS,
   parameter int W = cic3_readout_pkg::CH_W
) (
   input  logic [N-1:0] mask,
   output logic [W-1:0] idx,
   output logic         one_left
);
   always_comb begin
      idx = '0;
      for (int i = N - 1; i >= 0; i--)
         if (mask[i]) idx = W'(i);
   end
   // Clearing the lowest set bit leaves zero only for a single-bit mask.
   assign one_left = (mask != '0) && ((mask & (mask - N'(1))) == '0);
endmodule

// File: rtl/cic3_row_readout.sv
// cic3_row_readout: captures a CIC3 row's filter outputs and streams enabled channels.
//   clk, reset_n       clock and synchronous active-low reset
//   filt_data          NUM_FILTERS packed filter words, channel i at [i*DATA_W +: DATA_W]
//   sample_valid       new decimated sample set on filt_data
//   ch_enable          per-channel readout enable, latched at capture
//   rd_data/rd_chan    current word and its channel tag
//   rd_valid/rd_ready  output handshake
//   rd_last            current word is the last enabled channel of the frame
//   frame_cnt          number of accepted frames (wraps)
//   overrun            sticky flag for samples dropped while busy
//   overrun_clr        clears overrun (a simultaneous new overrun wins)
module cic3_row_readout
   import cic3_readout_pkg::*;
#(
   parameter int NUM_FILTERS = cic3_readout_pkg::NUM_FILTERS,
   parameter int DATA_W      = cic3_readout_pkg::DATA_W,
   parameter int CH_W        = cic3_readout_pkg::CH_W,
   parameter int FRAME_W     = cic3_readout_pkg::FRAME_W
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [NUM_FILTERS*DATA_W-1:0] filt_data,
   input  logic                          sample_valid,
   input  logic [NUM_FILTERS-1:0]        ch_enable,
   output logic [DATA_W-1:0]             rd_data,
   output logic [CH_W-1:0]               rd_chan,
   output logic                          rd_valid,
   input  logic                          rd_ready,
   output logic                          rd_last,
   output logic [FRAME_W-1:0]            frame_cnt,
   output logic                          overrun,
   input  logic                          overrun_clr
);
   state_t                   state;
   logic [NUM_FILTERS-1:0]   mask;
   logic [DATA_W-1:0]        shadow [NUM_FILTERS];
   logic [CH_W-1:0]          idx;
   logic                     one_left;
   logic                     xfer;
   logic                     fin;
   logic                     cap;
   logic                     ovr_set;

   cic3_prio_enc #(.N(NUM_FILTERS), .W(CH_W)) u_enc (
      .mask     (mask),
      .idx      (idx),
      .one_left (one_left)
   );

   // Outputs decode only from registered state; rd_ready steers the next cycle.
   assign rd_valid = (state == SEND);
   assign rd_chan  = idx;
   assign rd_last  = one_left;
   assign rd_data  = rd_valid ? shadow[idx] : '0;
   assign xfer     = rd_valid && rd_ready;
   assign fin      = xfer && one_left;
   // A sample is taken when idle or exactly as the final word leaves.
   assign cap      = sample_valid && (ch_enable != '0) && (state == IDLE || fin);
   assign ovr_set  = sample_valid && (state == SEND) && !fin;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= IDLE;
         mask      <= '0;
         frame_cnt <= '0;
         overrun   <= 1'b0;
         for (int i = 0; i < NUM_FILTERS; i++) shadow[i] <= '0;
      end else begin
         if (cap) begin
            for (int i = 0; i < NUM_FILTERS; i++) shadow[i] <= filt_data[i*DATA_W +: DATA_W];
            mask      <= ch_enable;
            frame_cnt <= frame_cnt + FRAME_W'(1);
            state     <= SEND;
         end else if (xfer) begin
            mask <= mask & ~(NUM_FILTERS'(1) << idx);
            if (one_left) state <= IDLE;
         end
         overrun <= ovr_set | (overrun & ~overrun_clr);
      end
   end
endmodule
